// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
// Provides the default word width, the two-state encoding and a helper
// that builds the first trial word (only the MSB set).
package sar_pkg;

  localparam int SAR_N = 4;

  // One-bit state encoding: the controller is either waiting or trialling.
  localparam logic IDLE  = 1'b0;
  localparam logic TRIAL = 1'b1;

  // First trial word for an n-bit search: MSB set, all other bits clear.
  function automatic int unsigned trial_init(int n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/comparatore4.sv
// Combinational 4-bit magnitude comparator, the partner of sar_comparatore.
// Ports: A, B (4-bit operands); GT (A>B), EQ (A==B), LT (A<B), exactly one high.
// Latency: zero (purely combinational); no backpressure.
module comparatore4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       GT,
  output logic       EQ,
  output logic       LT
);

  always_comb begin
    GT = (A > B);
    EQ = (A == B);
    LT = (A < B);
  end

endmodule

// File: rtl/sar_comparatore.sv
// Successive-approximation search: drives trial word B into an external
// comparator against an unknown A and rebuilds A on result from GT/EQ/LT.
// Ports: clk, rst_n (sync, active-low), start; GT/EQ/LT verdicts in;
//        B trial word, busy, done (1-cycle pulse), result, err (sticky) out.
// Latency: start edge to done cycle is 1 + k, k = trial cycles (1..N).
// start is only looked at while idle; the verdict is consumed every trial.
module sar_comparatore
  import sar_pkg::*;
#(
  parameter int N = SAR_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         GT,
  input  logic         EQ,
  input  logic         LT,
  output logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          state_q, state_d;
  logic [N-1:0]  b_q, b_d;
  logic [IW-1:0] i_q, i_d;
  logic [N-1:0]  result_q, result_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          onehot;
  logic [IW-1:0] i_m1;

  // Exactly one of three bits set: odd parity rules out 0 and 2 hot,
  // the AND term rules out all three.
  assign onehot = (GT ^ EQ ^ LT) & ~(GT & EQ & LT);
  assign i_m1   = i_q - 1'b1;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      b_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      i_q      <= i_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    i_d      = i_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRIAL;
          b_d     = N'(trial_init(N));
          i_d     = IW'(N - 1);
          err_d   = 1'b0;
        end
      end
      TRIAL: begin
        if (!onehot) begin
          err_d = 1'b1;
        end
        // Priority EQ > GT > LT; a verdict with nothing hot falls into LT.
        if (EQ || (i_q == '0)) begin
          result_d = b_q;
          if (!EQ && !GT) begin
            result_d[0] = 1'b0;
          end
          // Leave the comparator looking at the answer while idle.
          b_d     = result_d;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          b_d[i_m1] = 1'b1;
          if (!GT) begin
            b_d[i_q] = 1'b0;
          end
          i_d = i_m1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    B      = b_q;
    busy   = (state_q == TRIAL);
    done   = done_q;
    result = result_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_sar_comparatore.sv
module tb_sar_comparatore;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A;
  logic         c_gt, c_eq, c_lt;
  logic         ov, ov_gt, ov_eq, ov_lt;
  logic         GT, EQ, LT;
  logic [N-1:0] B;
  logic         busy, done, err;
  logic [N-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tcount = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] res;
    logic         err;
    int           c0;
    int           k;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comparatore4 u_cmp (.A(A), .B(B), .GT(c_gt), .EQ(c_eq), .LT(c_lt));

  // Verdict override lets the bench inject illegal verdict patterns.
  assign GT = ov ? ov_gt : c_gt;
  assign EQ = ov ? ov_eq : c_eq;
  assign LT = ov ? ov_lt : c_lt;

  sar_comparatore #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .GT(GT), .EQ(EQ), .LT(LT),
    .B(B), .busy(busy), .done(done), .result(result), .err(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: trial j (1-based) keeps A's bits above position N-j and
  // tries bit N-j set with everything below it clear.
  function automatic logic [N-1:0] trial_b(input logic [N-1:0] a, input int j);
    int m;
    m = (1 << N) - (1 << (N - j + 1));
    return N'((int'(a) & m) | (1 << (N - j)));
  endfunction

  // Number of trials: the search stops when the trial word equals A,
  // i.e. at the position of A's lowest set bit; A=0 needs every trial.
  function automatic int trials(input logic [N-1:0] a);
    int tz;
    if (a == '0) return N;
    tz = 0;
    while (a[tz] == 1'b0) tz++;
    return N - tz;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [N-1:0] a);
    exp_t e;
    A = a;
    start = 1'b1;
    step();
    start = 1'b0;
    e.a = a; e.res = a; e.err = 1'b0; e.c0 = cyc; e.k = trials(a);
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Monitor: tracks the trial sequence of the oldest pending search and
  // scores result, err, latency and final B whenever done is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_done_excl", int'(busy && done), 0);
      if (busy) begin
        if (sb_q.size() == 0) begin
          chk("busy_without_start", 1, 0);
        end else begin
          tcount++;
          chk("b_trace", int'(B), int'(trial_b(sb_q[0].a, tcount)));
        end
      end else if (done) begin
        if (sb_q.size() == 0) begin
          chk("done_without_start", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", int'(result), int'(e.res));
          chk("err", int'(err), int'(e.err));
          chk("latency", 1 + cyc - e.c0, 1 + e.k);
          chk("b_after_done", int'(B), int'(e.res));
        end
        tcount = 0;
      end else begin
        tcount = 0;
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; A = '0;
    ov = 1'b0; ov_gt = 1'b0; ov_eq = 1'b0; ov_lt = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_B", int'(B), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    // Directed searches, back-to-back.
    launch(4'b0000); wait_done();
    launch(4'b1111); wait_done();
    launch(4'b0101); wait_done();
    launch(4'b1000); wait_done();

    // Exhaustive, each start raised in the done cycle of the previous run.
    for (int a = 0; a < 16; a++) begin
      launch(N'(a));
      wait_done();
    end
    step(); step();

    // Illegal verdict GT=EQ=1 on trial 2 for A=0110: EQ wins, err set.
    A = 4'b0110;
    start = 1'b1;
    step();
    start = 1'b0;
    e.a = 4'b0110; e.res = 4'b0100; e.err = 1'b1; e.c0 = cyc; e.k = 2;
    sb_q.push_back(e);
    step();
    ov = 1'b1; ov_gt = 1'b1; ov_eq = 1'b1; ov_lt = 1'b0;
    step();
    ov = 1'b0;
    chk("err_set", int'(err), 1);
    step();
    chk("err_sticky", int'(err), 1);

    // Next accepted start clears err; extra start while busy is ignored.
    launch(4'b1001);
    chk("err_cleared", int'(err), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    step(); step();

    // Reset during trial 3 of a search for 1010.
    launch(4'b1010);
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sb_q.delete();
    chk("midrst_B", int'(B), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    step();
    launch(4'b1010); wait_done();

    // Randomized searches with idle gaps and stray starts while busy.
    for (int r = 0; r < 40; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      launch(N'($urandom_range(0, 15)));
      if (busy && ($urandom_range(0, 1) == 1)) begin
        start = 1'b1;
        step();
        start = 1'b0;
      end
      wait_done();
    end

    step(); step(); step();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
